// File: rtl/xadac_vload.sv
// xadac vector load stage: scoreboard-tracked AXI reads, returning byte-masked vectors
// for write-back. Up to 2**IdWidth loads in flight; R beats may return in any order.
//
//   state       | meaning
//   ST_IDLE     | entry free, id may be accepted
//   ST_WAIT_AR  | accepted, address not yet loaded into the AR register
//   ST_WAIT_R   | address issued (ar_done), waiting for the R beat
//   ST_WAIT_RSP | data captured (r_done), waiting for the response register
module xadac_vload #(
   parameter int IdWidth      = 3,
   parameter int AddrWidth    = 32,
   parameter int VecDataWidth = 64,
   parameter int VecLenWidth  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    exe_req_valid,
   output logic                    exe_req_ready,
   input  logic [IdWidth-1:0]      exe_req_id,
   input  logic [31:0]             exe_req_instr,
   input  logic [AddrWidth-1:0]    exe_req_rs0,
   output logic                    exe_rsp_valid,
   input  logic                    exe_rsp_ready,
   output logic [IdWidth-1:0]      exe_rsp_id,
   output logic [VecDataWidth-1:0] exe_rsp_vd_data,
   output logic                    exe_rsp_err,
   output logic [IdWidth-1:0]      axi_ar_id,
   output logic [AddrWidth-1:0]    axi_ar_addr,
   output logic                    axi_ar_valid,
   input  logic                    axi_ar_ready,
   input  logic [IdWidth-1:0]      axi_r_id,
   input  logic [VecDataWidth-1:0] axi_r_data,
   input  logic [1:0]              axi_r_resp,
   input  logic                    axi_r_valid,
   output logic                    axi_r_ready
);

   localparam int SbLen   = 2 ** IdWidth;
   localparam int NumElem = VecDataWidth / 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_AR,
      ST_WAIT_R,
      ST_WAIT_RSP
   } state_t;

   state_t                  state [SbLen];
   logic [AddrWidth-1:0]    addr  [SbLen];
   logic [VecLenWidth-1:0]  vlen  [SbLen];
   logic [VecDataWidth-1:0] data  [SbLen];
   logic                    err   [SbLen];

   logic [VecLenWidth-1:0]  req_vlen_raw;
   logic [VecLenWidth-1:0]  req_vlen;
   logic                    accept;
   logic                    ar_free;
   logic                    ar_pick_vld;
   logic [IdWidth-1:0]      ar_pick;
   logic [AddrWidth-1:0]    ar_pick_addr;
   logic                    r_hit;
   logic [VecDataWidth-1:0] r_masked;
   logic                    rsp_free;
   logic                    rsp_pick_vld;
   logic [IdWidth-1:0]      rsp_pick;
   logic                    unused_instr;

   assign unused_instr  = ^exe_req_instr;
   assign axi_r_ready   = 1'b1;
   assign exe_req_ready = exe_req_valid && (state[exe_req_id] == ST_IDLE);
   assign accept        = exe_req_ready;
   assign ar_free       = !axi_ar_valid || axi_ar_ready;
   assign rsp_free      = !exe_rsp_valid || exe_rsp_ready;
   assign r_hit         = axi_r_valid && (state[axi_r_id] == ST_WAIT_R);

   always_comb begin
      req_vlen_raw = exe_req_instr[25 +: VecLenWidth];
      if (int'(req_vlen_raw) > NumElem) begin
         req_vlen = VecLenWidth'(NumElem);
      end else begin
         req_vlen = req_vlen_raw;
      end
   end

   // A request accepted this cycle competes for the AR register; its address is
   // not in the scoreboard yet, so it is taken straight from rs0.
   always_comb begin
      ar_pick_vld = 1'b0;
      ar_pick     = '0;
      for (int i = SbLen - 1; i >= 0; i--) begin
         if ((state[i] == ST_WAIT_AR) ||
             (accept && (req_vlen != '0) && (exe_req_id == IdWidth'(i)))) begin
            ar_pick_vld = 1'b1;
            ar_pick     = IdWidth'(i);
         end
      end
      if (accept && (exe_req_id == ar_pick)) begin
         ar_pick_addr = exe_req_rs0;
      end else begin
         ar_pick_addr = addr[ar_pick];
      end
   end

   always_comb begin
      r_masked = '0;
      for (int b = 0; b < NumElem; b++) begin
         if (b < int'(vlen[axi_r_id])) begin
            r_masked[8*b +: 8] = axi_r_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      rsp_pick_vld = 1'b0;
      rsp_pick     = '0;
      for (int i = SbLen - 1; i >= 0; i--) begin
         if (state[i] == ST_WAIT_RSP) begin
            rsp_pick_vld = 1'b1;
            rsp_pick     = IdWidth'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SbLen; i++) begin
            state[i] <= ST_IDLE;
            addr[i]  <= '0;
            vlen[i]  <= '0;
            data[i]  <= '0;
            err[i]   <= 1'b0;
         end
         axi_ar_valid    <= 1'b0;
         axi_ar_id       <= '0;
         axi_ar_addr     <= '0;
         exe_rsp_valid   <= 1'b0;
         exe_rsp_id      <= '0;
         exe_rsp_vd_data <= '0;
         exe_rsp_err     <= 1'b0;
      end else begin
         if (accept) begin
            addr[exe_req_id]  <= exe_req_rs0;
            vlen[exe_req_id]  <= req_vlen;
            data[exe_req_id]  <= '0;
            err[exe_req_id]   <= 1'b0;
            state[exe_req_id] <= (req_vlen == '0) ? ST_WAIT_RSP : ST_WAIT_AR;
         end

         // Later assignment wins when the AR pick is the entry accepted this cycle.
         if (ar_free) begin
            axi_ar_valid <= ar_pick_vld;
            if (ar_pick_vld) begin
               axi_ar_id      <= ar_pick;
               axi_ar_addr    <= ar_pick_addr;
               state[ar_pick] <= ST_WAIT_R;
            end
         end

         if (r_hit) begin
            data[axi_r_id]  <= r_masked;
            err[axi_r_id]   <= (axi_r_resp != 2'b00);
            state[axi_r_id] <= ST_WAIT_RSP;
         end

         if (rsp_free) begin
            exe_rsp_valid <= rsp_pick_vld;
            if (rsp_pick_vld) begin
               exe_rsp_id      <= rsp_pick;
               exe_rsp_vd_data <= data[rsp_pick];
               exe_rsp_err     <= err[rsp_pick];
               state[rsp_pick] <= ST_IDLE;
               addr[rsp_pick]  <= '0;
               vlen[rsp_pick]  <= '0;
               data[rsp_pick]  <= '0;
               err[rsp_pick]   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/xadac_vload.md
Name: xadac_vload

Overview:
- Vector load stage of the xadac coprocessor; sibling of the vector activation/store unit and mirror of its datapath.
- Accepts load exe requests tagged with a scoreboard id and fetches vector data through an AXI AR/R read channel.
- Returns the byte-masked vector in an exe response for write-back into the vector register file.
- Supports up to 2**IdWidth outstanding loads; AXI R beats may return out of order.

Parameters:
IdWidth, 3, scoreboard id width; SbLen = 2**IdWidth entries
AddrWidth, 32, AXI address width
VecDataWidth, 64, vector width in bits; NumElem = VecDataWidth/8 byte elements
VecLenWidth, 4, width of the vlen field in the instruction

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exe_req_valid  in  1  load request valid
exe_req_ready  out  1  load request ready
exe_req_id  in  IdWidth  scoreboard id
exe_req_instr  in  32  instruction; vlen = instr[25 +: VecLenWidth]
exe_req_rs0  in  AddrWidth  base address
exe_rsp_valid  out  1  response valid (registered)
exe_rsp_ready  in  1  response ready
exe_rsp_id  out  IdWidth  id of completed load
exe_rsp_vd_data  out  VecDataWidth  loaded vector
exe_rsp_err  out  1  AXI error seen on this load
axi_ar_id  out  IdWidth  read id, equals scoreboard id
axi_ar_addr  out  AddrWidth  read address
axi_ar_valid  out  1  AR valid (registered)
axi_ar_ready  in  1  AR ready
axi_r_id  in  IdWidth  read response id
axi_r_data  in  VecDataWidth  read data
axi_r_resp  in  2  AXI response code
axi_r_valid  in  1  R valid
axi_r_ready  out  1  R ready

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all scoreboard entries cleared. exe_rsp_valid, exe_rsp_id, exe_rsp_vd_data, exe_rsp_err, axi_ar_valid, axi_ar_id and axi_ar_addr are all 0. axi_r_ready is 1 from the first cycle after reset.
- Scoreboard entry fields: addr, vlen, data, err, and the flags busy, ar_done, r_done.
- Entry lifecycle: IDLE -> WAIT_AR -> WAIT_R -> WAIT_RSP -> IDLE.
- Request acceptance: exe_req_ready = exe_req_valid && !busy[exe_req_id]. busy is the registered state, so an id freed in cycle N is accepted no earlier than cycle N+1.
- On accept:
  - addr = rs0.
  - vlen = min(instr vlen, NumElem).
  - busy = 1.
  - If vlen == 0, also set ar_done = r_done = 1 with data = 0, so the entry goes straight to WAIT_RSP and no AXI traffic is issued.
- AR channel:
  - The AR output register clears when axi_ar_valid && axi_ar_ready.
  - When the register is empty (after that clear), it loads the lowest-index entry with busy && !ar_done (this includes an entry accepted in the same cycle), then sets that entry's ar_done.
  - axi_ar_valid is held stable until the handshake.
  - Earliest timing: accept in cycle N gives axi_ar_valid at N+1. Back-to-back AR issue every cycle is possible.
- R channel:
  - axi_r_ready is constant 1.
  - On a beat whose entry has ar_done && !r_done: data = r_data with bytes at index >= vlen forced to 0; err = (r_resp != 0); r_done = 1.
  - A beat for an entry in any other state is dropped silently (no state change).
- Response channel:
  - The response register clears on exe_rsp_valid && exe_rsp_ready.
  - When empty, it loads the lowest-index entry with r_done, driving id, data and err. That entry is cleared to 0 (freed) in the same cycle.
  - Earliest timing: R beat in cycle M gives exe_rsp_valid at M+1.
  - Outputs are held stable while exe_rsp_valid && !exe_rsp_ready.
- Ordering: responses follow R completion order, with ties broken by lowest id. No in-order guarantee across ids.
- Simultaneous events: accept, AR issue, R capture and response load may all target different entries in one cycle. An R beat and a response load never hit the same entry in one cycle, because the response load only sees registered r_done.
- Reset mid-operation: all pending loads are discarded. Late R beats for discarded loads are dropped by the state check. AR handshakes completing after reset are the interconnect's concern.

Test Plan:
- Single load: id=2, rs0=0x1000, vlen=8; R id=2, data 0x8877665544332211 -> AR (2, 0x1000) at N+1; exe_rsp id=2, data 0x8877665544332211, err=0 one cycle after R.
- Masking and clamp: vlen=3 with R data 0xFFFFFFFFFFFFFFFF -> vd_data 0x0000000000FFFFFF. vlen=15 -> treated as 8, full data returned.
- Zero length: vlen=0, id=5 -> no AR issued; exe_rsp id=5, data 0 at N+2.
- Out-of-order: ids 0,1,2 accepted; R returns 2,0,1 -> responses in order 2,0,1 with matching data. A new id 2 request is refused until the cycle after rsp 2 fires.
- Backpressure: axi_ar_ready=0 for 5 cycles and exe_rsp_ready=0 for 4 cycles -> AR and rsp outputs held stable; nothing lost; all 8 ids eventually complete.
- Error and reset: r_resp=2 -> exe_rsp_err=1. Assert rst with 3 loads in flight -> all outputs 0 next cycle; a later stale R beat produces no response.
